// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if: groups the request/stream handshake and SPI pins of
// spi_flash_reader.
//   slave  : the read engine (consumes start/addr/len/m_ready/miso,
//            drives busy/done/m_data/m_valid/cs_n/sclk/mosi)
//   master : the user logic / flash side that talks to the engine
// Stream handshake: a byte moves when m_valid && m_ready are both high at a
// rising clk edge; once m_valid is high, m_valid and m_data stay stable until
// that transfer happens.
interface spi_flash_reader_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [23:0]      addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_ready;
  logic             cs_n;
  logic             sclk;
  logic             mosi;
  logic             miso;

  modport slave (
    input  start, addr, len, m_ready, miso,
    output busy, done, m_data, m_valid, cs_n, sclk, mosi
  );

  modport master (
    output start, addr, len, m_ready, miso,
    input  busy, done, m_data, m_valid, cs_n, sclk, mosi
  );
endinterface

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI NOR flash read engine (mode 0). Sends READ (0x03) plus a
// 24-bit address, then streams len bytes out on a valid/ready byte port.
// SCLK is held low while a completed byte cannot be handed to the output
// register, so the consumer can stall the flash without losing data.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : spi_flash_reader_if.slave (start/addr/len/busy/done,
//               m_data/m_valid/m_ready, cs_n/sclk/mosi/miso)
//   dbg_state : current FSM state encoding
//
// Optional feature: define SPI_FAST_READ_EN to issue FAST_READ (0x0B) with
// 8 dummy clocks between address and data.
module spi_flash_reader #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 16,
  parameter int CS_GAP  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_flash_reader_if.slave     bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DUMMY = 3'd3,
    S_DATA  = 3'd4,
    S_END   = 3'd5,
    S_GAP   = 3'd6
  } state_t;

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] OPCODE    = 8'h0B;
  localparam state_t     ADDR_NEXT = S_DUMMY;
`else
  localparam logic [7:0] OPCODE    = 8'h03;
  localparam state_t     ADDR_NEXT = S_DATA;
`endif

  localparam logic [LEN_W-1:0] ONE      = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0]       GAP_LAST = 8'(CS_GAP - 1);

  state_t           state;
  logic [31:0]      tx_sh;      // bits still to send after the one on mosi
  logic [7:0]       rx_sh;
  logic             rx_full;    // rx_sh holds a complete byte not yet moved out
  logic             miso_q;
  logic             last_byte;
  logic [LEN_W-1:0] rem;
  logic [7:0]       div_cnt;
  logic [7:0]       gap_cnt;
  logic [4:0]       bit_cnt;    // sclk rises seen in the current state/byte
  logic             cs_n_q, sclk_q, mosi_q, busy_q, done_q, out_valid;
  logic [7:0]       out_data;

  logic shifting, phase_end, stall, drain, rise, fall;

  assign shifting  = (state == S_CMD) || (state == S_ADDR) ||
                     (state == S_DUMMY) || (state == S_DATA);
  assign phase_end = (div_cnt == DIV_LAST);
  // A finished byte still waiting for the output register freezes the low
  // phase, so no further miso bit is clocked in until it has moved over.
  assign stall     = (state == S_DATA) && !sclk_q && rx_full;
  assign drain     = out_valid && bus.m_ready;
  assign rise      = shifting && phase_end && !stall && !sclk_q;
  assign fall      = shifting && phase_end && sclk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rx_full   <= 1'b0;
      miso_q    <= 1'b0;
      last_byte <= 1'b0;
      rem       <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      done_q <= 1'b0;
      miso_q <= bus.miso;

      // Output register: refill from rx when empty or draining this cycle.
      if (rx_full && (!out_valid || drain)) begin
        out_data  <= rx_sh;
        out_valid <= 1'b1;
        rx_full   <= 1'b0;
      end else if (drain) begin
        out_valid <= 1'b0;
      end

      // SCLK generator: CLK_DIV cycles per phase, paused while stalled.
      if (shifting && !stall) begin
        if (phase_end) begin
          div_cnt <= '0;
          sclk_q  <= !sclk_q;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.len == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q    <= 1'b1;
              cs_n_q    <= 1'b0;
              mosi_q    <= OPCODE[7];
              tx_sh     <= {OPCODE[6:0], bus.addr, 1'b0};
              rem       <= bus.len;
              bit_cnt   <= '0;
              div_cnt   <= '0;
              sclk_q    <= 1'b0;
              last_byte <= 1'b0;
              state     <= S_CMD;
            end
          end
        end

        S_CMD, S_ADDR: begin
          if (rise) bit_cnt <= bit_cnt + 5'd1;
          if (fall) begin
            mosi_q <= tx_sh[31];
            tx_sh  <= {tx_sh[30:0], 1'b0};
            if (state == S_CMD && bit_cnt == 5'd8) begin
              bit_cnt <= '0;
              state   <= S_ADDR;
            end else if (state == S_ADDR && bit_cnt == 5'd24) begin
              bit_cnt <= '0;
              mosi_q  <= 1'b0;
              state   <= ADDR_NEXT;
            end
          end
        end

        S_DUMMY: begin
          if (rise) bit_cnt <= bit_cnt + 5'd1;
          if (fall && bit_cnt == 5'd8) begin
            bit_cnt <= '0;
            state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (rise) begin
            rx_sh <= {rx_sh[6:0], miso_q};
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              rx_full <= 1'b1;
              rem     <= rem - ONE;
              if (rem == ONE) last_byte <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          if (fall && last_byte) state <= S_END;
        end

        S_END: begin
          cs_n_q  <= 1'b1;
          gap_cnt <= '0;
          state   <= S_GAP;
        end

        S_GAP: begin
          // Finish only once the gap has elapsed and no byte is left behind.
          if (gap_cnt >= GAP_LAST && !rx_full && (!out_valid || drain)) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else if (gap_cnt != 8'hFF) begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.m_data  = out_data;
  assign bus.m_valid = out_valid;
  assign bus.cs_n    = cs_n_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed bench for spi_flash_reader with a mode-0 SPI
// flash model, a byte scoreboard and protocol monitors.
`timescale 1ns/1ps
module tb_spi_flash_reader;
  localparam int CLK_DIV = 2;
  localparam int LEN_W   = 16;
  localparam int CS_GAP  = 4;
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] EXP_OP     = 8'h0B;
  localparam int         DATA_START = 40;
`else
  localparam logic [7:0] EXP_OP     = 8'h03;
  localparam int         DATA_START = 32;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  spi_flash_reader_if #(.LEN_W(LEN_W)) bus ();

  spi_flash_reader #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W), .CS_GAP(CS_GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- flash model + monitors ----------------
  int cyc = 0, txn_rises = 0, tot_rises = 0, last_rise_cyc = 0;
  int rises_at_valid = 0, valid_lag = 0, done_cnt = 0, mosi_viol = 0;
  int hi_run = 0, last_hi_run = 0;
  logic prev_sclk = 1'b0, prev_mosi = 1'b0, prev_cs_n = 1'b1, prev_valid = 1'b0;
  logic first_pending = 1'b0;
  logic [31:0] cmd_word = '0;

  function automatic logic [7:0] mem_at(input logic [23:0] a);
    case (a)
      24'h123456: return 8'hDE;
      24'h123457: return 8'hAD;
      24'h123458: return 8'hBE;
      24'h123459: return 8'hEF;
      default:    return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  always @(negedge clk) begin
    int d;
    logic [7:0] b;
    cyc++;
    if (bus.done === 1'b1) done_cnt++;
    if (bus.m_valid === 1'b1 && !prev_valid && first_pending) begin
      rises_at_valid = txn_rises;
      valid_lag      = cyc - last_rise_cyc;
      first_pending  = 1'b0;
    end
    if (bus.cs_n !== 1'b0) begin
      hi_run++;
      txn_rises = 0;
      bus.miso  = 1'b0;
    end else begin
      if (prev_cs_n) begin
        last_hi_run   = hi_run;
        first_pending = 1'b1;
      end
      hi_run = 0;
      if (bus.sclk && !prev_sclk) begin
        txn_rises++;
        tot_rises++;
        last_rise_cyc = cyc;
        if (txn_rises <= 32) cmd_word = {cmd_word[30:0], bus.mosi};
        else if (bus.mosi !== 1'b0) mosi_viol++;
      end
      if (!bus.sclk && prev_sclk && txn_rises >= DATA_START) begin
        d = txn_rises - DATA_START;
        b = mem_at(cmd_word[23:0] + 24'(d / 8));
        bus.miso = b[7 - (d % 8)];
      end
    end
    if (bus.sclk && prev_sclk && bus.mosi !== prev_mosi) mosi_viol++;
    if (bus.cs_n && bus.mosi !== 1'b0) mosi_viol++;
    prev_sclk  = bus.sclk;
    prev_mosi  = bus.mosi;
    prev_cs_n  = bus.cs_n;
    prev_valid = bus.m_valid;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data = '0;

  always @(negedge clk) begin
    if (hold_pending)
      check("hold_stable", 32'({bus.m_valid, bus.m_data}), 32'({1'b1, hold_data}));
    if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      if (exp_q.size() == 0) check("stream_extra", 32'(bus.m_data), 32'h100);
      else check("stream_byte", 32'(bus.m_data), 32'(exp_q.pop_front()));
    end
    hold_pending = (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
    hold_data    = bus.m_data;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_read(input logic [23:0] a, input logic [LEN_W-1:0] l);
    bus.addr  = a;
    bus.len   = l;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (bus.done !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(bus.done === 1'b1), 32'd1);
  endtask

  task automatic wait_rises(input int target, input int max_cyc);
    int n = 0;
    while (txn_rises < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("rises_reached", 32'(txn_rises >= target), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int d0, r0, n;

  initial begin
    bus.start   = 1'b0;
    bus.addr    = '0;
    bus.len     = '0;
    bus.m_ready = 1'b1;
    bus.miso    = 1'b0;
    rst         = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_cs_n",    32'(bus.cs_n),    32'd1);
    check("rst_sclk",    32'(bus.sclk),    32'd0);
    check("rst_mosi",    32'(bus.mosi),    32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data",  32'(bus.m_data),  32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic read: 0x123456, 4 bytes, consumer always ready.
    exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    d0 = done_cnt;
    r0 = tot_rises;
    start_read(24'h123456, 16'd4);
    @(negedge clk);
    check("t1_cs_n_low", 32'(bus.cs_n), 32'd0);
    check("t1_busy",     32'(bus.busy), 32'd1);
    check("t1_mosi_op7", 32'(bus.mosi), 32'(EXP_OP[7]));
    @(negedge clk);
    check("t2_sclk_low", 32'(bus.sclk), 32'd0);
    @(negedge clk);
    check("t3_sclk_high", 32'(bus.sclk), 32'd1);
    wait_done(2000);
    check("basic_busy_clr", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("basic_done_pulse", 32'(bus.done), 32'd0);
    check("basic_cmd",        cmd_word, {EXP_OP, 24'h123456});
    check("basic_rises",      32'(tot_rises - r0), 32'(DATA_START + 32));
    check("basic_done_cnt",   32'(done_cnt - d0), 32'd1);
    check("first_valid_rise", 32'(rises_at_valid), 32'(DATA_START + 8));
    check("first_valid_lag",  32'(valid_lag), 32'd1);
    check("basic_q_empty",    32'(exp_q.size()), 32'd0);

    // Backpressure: len=3 at 0x000100, consumer stalls for 100 cycles.
    tick();
    bus.m_ready = 1'b0;
    exp_q.push_back(8'h5B); exp_q.push_back(8'h5A); exp_q.push_back(8'h59);
    d0 = done_cnt;
    start_read(24'h000100, 16'd3);
    n = 0;
    while (bus.m_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("bp_first_valid", 32'(bus.m_valid), 32'd1);
    repeat (100) @(negedge clk);
    check("bp_sclk_held",  32'(bus.sclk), 32'd0);
    check("bp_cs_n_low",   32'(bus.cs_n), 32'd0);
    check("bp_busy",       32'(bus.busy), 32'd1);
    check("bp_rises_held", 32'(txn_rises), 32'(DATA_START + 16));
    check("bp_data_held",  32'(bus.m_data), 32'h5B);
    tick();
    bus.m_ready = 1'b1;
    wait_done(2000);
    @(negedge clk);
    check("bp_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("bp_q_empty",  32'(exp_q.size()), 32'd0);

    // len=0: done at T+1, no SPI activity.
    tick();
    d0 = done_cnt;
    r0 = tot_rises;
    start_read(24'h777777, 16'd0);
    @(negedge clk);
    check("len0_done", 32'(bus.done), 32'd1);
    check("len0_busy", 32'(bus.busy), 32'd0);
    check("len0_cs_n", 32'(bus.cs_n), 32'd1);
    @(negedge clk);
    check("len0_done_pulse", 32'(bus.done), 32'd0);
    repeat (5) @(negedge clk);
    check("len0_no_sclk", 32'(tot_rises - r0), 32'd0);
    check("len0_cs_n_hi", 32'(bus.cs_n), 32'd1);

    // Start while busy is ignored; then back-to-back start honours the gap.
    tick();
    exp_q.push_back(8'hFA); exp_q.push_back(8'hFB);
    start_read(24'h0000A0, 16'd2);
    wait_rises(DATA_START + 4, 1000);
    tick();
    bus.addr  = 24'hFFFF00;
    bus.len   = 16'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    check("ign_busy", 32'(bus.busy), 32'd1);
    wait_done(2000);
    exp_q.push_back(8'h4A);
    bus.addr  = 24'h000010;
    bus.len   = 16'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("gap_cs_n_low", 32'(bus.cs_n), 32'd0);
    check("gap_len",      32'(last_hi_run >= CS_GAP), 32'd1);
    check("ign_cmd",      cmd_word, {EXP_OP, 24'h0000A0});
    wait_done(2000);
    @(negedge clk);
    check("b2b_cmd",     cmd_word, {EXP_OP, 24'h000010});
    check("ign_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of the address phase, then a clean read.
    tick();
    start_read(24'h0ABCDE, 16'd2);
    wait_rises(20, 1000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_cs_n",    32'(bus.cs_n),    32'd1);
    check("mid_rst_sclk",    32'(bus.sclk),    32'd0);
    check("mid_rst_mosi",    32'(bus.mosi),    32'd0);
    check("mid_rst_busy",    32'(bus.busy),    32'd0);
    check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_done",    32'(bus.done),    32'd0);
    tick();
    exp_q.push_back(8'h4A);
    start_read(24'h000010, 16'd1);
    wait_done(2000);
    @(negedge clk);
    check("post_rst_cmd",     cmd_word, {EXP_OP, 24'h000010});
    check("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef SPI_FAST_READ_EN
    // FAST_READ: opcode 0x0B, 8 dummy clocks, first byte after 48th rise.
    tick();
    exp_q.push_back(8'h5A); exp_q.push_back(8'h5B);
    r0 = tot_rises;
    start_read(24'h000000, 16'd2);
    wait_done(2000);
    @(negedge clk);
    check("fast_cmd",         cmd_word, 32'h0B000000);
    check("fast_first_valid", 32'(rises_at_valid), 32'd48);
    check("fast_rises",       32'(tot_rises - r0), 32'd56);
    check("fast_q_empty",     32'(exp_q.size()), 32'd0);
`endif

    repeat (5) @(negedge clk);
    check("mosi_rules", 32'(mosi_viol), 32'd0);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Fabric-side SPI NOR flash read engine sharing the configuration flash with the JTAG-to-SPI programming bridge: once programming is finished and the JTAG path is idle, user logic uses this block to fetch data from the flash. It issues a standard READ command (0x03) with a 24-bit address. It then streams the requested number of bytes out on a valid/ready byte interface. SCLK is stalled whenever the consumer applies backpressure.

## Interface
- CLK_DIV, 2: SCLK half-period in clk cycles (≥1); SCLK period = 2·CLK_DIV clk cycles.
- LEN_W, 16: width of byte-count input.
- CS_GAP, 4: minimum clk cycles cs_n stays high between transactions.

- clk  in  1  system clock; every register in the block is clocked by clk.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a read; accepted only when busy=0.
- addr  in  24  flash byte address, sampled on accepted start.
- len  in  LEN_W  byte count, sampled on accepted start; 0 = no-op.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at transaction end.
- m_data  out  8  read byte, MSB first off the wire.
- m_valid  out  1  m_data valid; held with m_data stable until m_ready.
- m_ready  in  1  consumer accepts byte when m_valid && m_ready.
- cs_n  out  1  flash chip select, active low.
- sclk  out  1  SPI clock, mode 0 (idle low).
- mosi  out  1  SPI data to flash.
- miso  in  1  SPI data from flash (d1); registered once before use.

## Operation
- States: IDLE → CMD (8 bits) → ADDR (24 bits) → [DUMMY, FAST_READ_EN only] → DATA → END → GAP → IDLE.
- IDLE: start && !busy latches addr/len, sets busy. If len=0: done pulses next cycle, busy clears with it, cs_n never falls.
- CMD/ADDR: shift out opcode then addr[23:0], MSB first. mosi changes only while sclk low. mosi=0 in DATA/DUMMY and whenever cs_n=1.
- DATA: miso sampled on each sclk rising edge into an 8-bit shift register. After the 8th sample, the byte moves to the output register and m_valid sets, provided the output register is empty or is being drained in the same cycle.
- Backpressure: if a byte completes while the output register is still full, hold sclk low. Resume on the cycle after the handshake; the held byte moves over at that time. cs_n stays low while stalled. No byte is lost or duplicated.
- Remaining-count decrements at each byte capture. After the last byte's 8th rising edge, sclk returns low after CLK_DIV cycles. cs_n rises one cycle later (END).
- GAP: cs_n high for CS_GAP cycles. done pulses and busy clears on the first cycle where GAP has finished and the last byte has been accepted. Both are required.
- start while busy=1 is ignored. Nothing is queued.
- rst in any state, mid-byte included: next cycle cs_n=1, sclk=0, mosi=0, m_valid=0, busy=0, done=0. Partial byte is discarded. State returns to IDLE.

## Timing
- Reset values: cs_n=1, sclk=0, mosi=0, m_valid=0, m_data=0, busy=0, done=0.
- Accepted start at cycle T: busy=1 and cs_n=0 at T+1, with mosi = opcode bit 7. First sclk rise at T+1+CLK_DIV.
- Each bit takes a low phase of CLK_DIV cycles and a high phase of CLK_DIV cycles. mosi updates on the cycle sclk falls.
- miso is sampled from the registered copy on the cycle sclk rises. Flash output delay plus 1 clk must be less than CLK_DIV cycles.
- First data byte: m_valid rises 1 cycle after the 40th rising edge (READ). FAST_READ_EN: after the 48th.
- Without stalls, throughput is one byte per 16·CLK_DIV cycles.

## Configuration
- SPI_FAST_READ_EN defined: opcode 0x0B. DUMMY state adds 8 sclk cycles, mosi=0, miso ignored.
- Undefined: opcode 0x03, no DUMMY state.

## Test plan
- Reset: assert rst mid-ADDR → next cycle cs_n=1, sclk=0, busy=0, m_valid=0. A following start with addr=0x000010, len=1 runs cleanly.
- Basic read: addr=0x123456, len=4, m_ready=1. Flash model returns 0xDE,0xAD,0xBE,0xEF. Check: mosi carries 0x03,0x12,0x34,0x56; stream is DE AD BE EF; done pulses once; 32+32 sclk rises total.
- Backpressure: len=3, m_ready=0 for 100 cycles after the first byte. sclk holds low after byte 2 completes, with cs_n=0. After release all 3 bytes arrive in order.
- len=0: start → done at T+1, cs_n stays 1, no sclk edges.
- start while busy: second start with a different addr mid-DATA → ignored, first transfer's bytes unaffected. After done, cs_n stays high ≥CS_GAP cycles before a new start lowers it.
- SPI_FAST_READ_EN build: addr=0x000000, len=2 → opcode 0x0B, 8 dummy clocks, first m_valid after the 48th sclk rise.
